// File: rtl/frac_dsp16_pkg.sv
// Shared encodings for the fracturable 16-bit DSP accumulate stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frac_dsp16_pkg;

  // Burst FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Product stream modes
  localparam logic MODE_32     = 1'b0;  // one 32-bit product per beat
  localparam logic MODE_DUAL16 = 1'b1;  // two independent 16-bit products per beat

  localparam int PROD_W      = 32;
  localparam int LANE_PROD_W = 16;

endpackage

// File: rtl/frac_acc_lane.sv
// One W-bit accumulator lane: registered adder with carry chain, optional clamp.
// Latency: sum registered one cycle after en; cout/ovf are combinational on the current add.
// Backpressure: none; the owner gates updates with en.
module frac_acc_lane #(
  parameter int W   = 20,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         en,         // apply this beat's add
  input  logic         load,       // first beat: add onto zero instead of the held value
  input  logic         clr,        // flush to zero, wins over en
  input  logic [W-1:0] addend,
  input  logic         cin,
  input  logic         clamp_req,  // overflow of the unit this lane belongs to
  output logic [W-1:0] acc,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0] base;
  logic [W:0]   sum;

  assign base = load ? '0 : acc;
  assign sum  = {1'b0, base} + {1'b0, addend} + {{W{1'b0}}, cin};
  assign cout = sum[W];
  assign ovf  = en & cout;

  // Accumulator register: clear, else clamp to all-ones or wrap on update
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= ((SAT != 0) && clamp_req) ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/frac_dsp16_acc.sv
// Burst accumulator for the fracturable DSP product stream (1x32b or 2x16b lanes).
// Latency: out_valid rises the cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result is held; released by out_valid & out_ready.
module frac_dsp16_acc
  import frac_dsp16_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [31:0]      in_product,
  input  logic             in_last,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  localparam int LW = ACC_W / 2;

  state_t           state;
  logic             mode_q;
  logic             mode_eff;
  logic             first;
  logic             accept;
  logic [CNT_W-1:0] beat_cnt;
  logic             ovf_q;
  logic             ovf_now;

  logic [ACC_W-1:0] add_wide;
  logic [LW-1:0]    lo_add, hi_add;
  logic [LW-1:0]    lo_acc, hi_acc;
  logic             lo_cout, hi_cout;
  logic             lo_ovf, hi_ovf;
  logic             hi_cin;
  logic             lo_clamp_req;

  assign in_ready = (state != ST_HOLD);
  // A beat arriving alongside clear is discarded
  assign accept   = in_valid & in_ready & ~clear;
  assign first    = (state == ST_IDLE);
  // Mode is sampled on the first beat only; later beats use the latched burst mode
  assign mode_eff = first ? in_mode : mode_q;

  assign add_wide = {{(ACC_W-PROD_W){1'b0}}, in_product};

  // Lane addends: split the wide product in mode 0, per-lane 16-bit products in mode 1
  always_comb begin
    lo_add = add_wide[LW-1:0];
    hi_add = add_wide[ACC_W-1:LW];
    if (mode_eff == MODE_DUAL16) begin
      lo_add = {{(LW-LANE_PROD_W){1'b0}}, in_product[15:0]};
      hi_add = {{(LW-LANE_PROD_W){1'b0}}, in_product[31:16]};
    end
  end

  // Lanes are chained into one wide adder only in mode 0
  assign hi_cin       = (mode_eff == MODE_32) & lo_cout;
  // In mode 0 the whole accumulator clamps together on the top carry
  assign lo_clamp_req = (mode_eff == MODE_DUAL16) ? lo_cout : hi_cout;
  assign ovf_now      = (mode_eff == MODE_DUAL16) ? (lo_ovf | hi_ovf) : hi_ovf;

  frac_acc_lane #(.W(LW), .SAT(SAT)) u_lo (
    .clk       (clk),
    .resetb    (resetb),
    .en        (accept),
    .load      (first),
    .clr       (clear),
    .addend    (lo_add),
    .cin       (1'b0),
    .clamp_req (lo_clamp_req),
    .acc       (lo_acc),
    .cout      (lo_cout),
    .ovf       (lo_ovf)
  );

  frac_acc_lane #(.W(LW), .SAT(SAT)) u_hi (
    .clk       (clk),
    .resetb    (resetb),
    .en        (accept),
    .load      (first),
    .clr       (clear),
    .addend    (hi_add),
    .cin       (hi_cin),
    .clamp_req (hi_cout),
    .acc       (hi_acc),
    .cout      (hi_cout),
    .ovf       (hi_ovf)
  );

  // Burst FSM with registered out_valid; clear beats any beat or result handshake
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      mode_q    <= MODE_32;
    end else if (clear) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q <= in_mode;
            if (in_last) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept && in_last) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Beat counter (saturating) and sticky overflow, both restarted on a burst's first beat
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      beat_cnt <= '0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      if (first) begin
        beat_cnt <= CNT_W'(1);
        ovf_q    <= ovf_now;
      end else begin
        if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
        ovf_q <= ovf_q | ovf_now;
      end
    end
  end

  assign out_acc   = {hi_acc, lo_acc};
  assign out_beats = beat_cnt;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_frac_dsp16_acc.sv
// Directed bench for frac_dsp16_acc: wrap (SAT=0) and clamp (SAT=1) instances share stimulus.
// Latency: results checked 1 ns after the edge that makes them visible.
// Backpressure: out_ready held low to exercise HOLD.
module tb_frac_dsp16_acc;

  logic        clk = 1'b0;
  logic        resetb;
  logic        in_valid, in_mode, in_last, clear, out_ready;
  logic [31:0] in_product;

  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [39:0] w_out_acc;
  logic [7:0]  w_out_beats;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [39:0] s_out_acc;
  logic [7:0]  s_out_beats;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  frac_dsp16_acc #(.ACC_W(40), .CNT_W(8), .SAT(0)) u_wrap (
    .clk(clk), .resetb(resetb), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_mode(in_mode), .in_product(in_product), .in_last(in_last), .clear(clear),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc),
    .out_beats(w_out_beats), .out_ovf(w_out_ovf)
  );

  frac_dsp16_acc #(.ACC_W(40), .CNT_W(8), .SAT(1)) u_sat (
    .clk(clk), .resetb(resetb), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_mode(in_mode), .in_product(in_product), .in_last(in_last), .clear(clear),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
    .out_beats(s_out_beats), .out_ovf(s_out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One beat, accepted on the next edge (caller guarantees in_ready)
  task automatic beat(input logic mode, input logic [31:0] p, input logic last);
    in_valid   = 1'b1;
    in_mode    = mode;
    in_product = p;
    in_last    = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_last = 1'b0;
    clear = 1'b0; out_ready = 1'b0; in_product = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", w_out_valid, 0);
    check("rst_out_acc",   w_out_acc,   0);
    check("rst_in_ready",  w_in_ready,  1);
    check("rst_beats",     s_out_beats, 0);
    resetb = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", w_in_ready, 1);

    // Mode 0 carries from bit 15 into bit 16
    beat(1'b0, 32'h0000FFFF, 1'b0);
    beat(1'b0, 32'h00010000, 1'b0);
    check("m0_mid_valid", w_out_valid, 0);
    beat(1'b0, 32'h00000001, 1'b1);
    check("m0_valid",    w_out_valid, 1);
    check("m0_acc",      w_out_acc,   40'h0000020000);
    check("m0_beats",    w_out_beats, 3);
    check("m0_ovf",      w_out_ovf,   0);
    check("m0_in_ready", w_in_ready,  0);
    take_result();
    check("m0_released", w_out_valid, 0);

    // Mode 1: lanes independent; in_mode on the 2nd beat must be ignored
    beat(1'b1, 32'hFFFF0001, 1'b0);
    beat(1'b0, 32'hFFFF0001, 1'b1);
    check("m1_acc",   w_out_acc,   40'h1FFFE00002);
    check("m1_ovf",   w_out_ovf,   0);
    check("m1_beats", w_out_beats, 2);
    take_result();

    // Mode 1 lane overflow after 17 beats of all-ones
    repeat (16) beat(1'b1, 32'hFFFFFFFF, 1'b0);
    beat(1'b1, 32'hFFFFFFFF, 1'b1);
    check("m1ovf_wrap_acc", w_out_acc,   40'h0FFEF0FFEF);
    check("m1ovf_wrap_ovf", w_out_ovf,   1);
    check("m1ovf_beats",    w_out_beats, 17);
    check("m1ovf_sat_acc",  s_out_acc,   40'hFFFFFFFFFF);
    check("m1ovf_sat_ovf",  s_out_ovf,   1);

    // HOLD with out_ready low: inputs offered but nothing absorbed
    in_valid = 1'b1; in_mode = 1'b0; in_product = 32'h12345678; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_in_ready", w_in_ready,  0);
      check("hold_valid",    w_out_valid, 1);
      check("hold_acc",      w_out_acc,   40'h0FFEF0FFEF);
      check("hold_beats",    w_out_beats, 17);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take_result();
    check("rel_valid",    w_out_valid, 0);
    check("rel_in_ready", w_in_ready,  1);
    beat(1'b0, 32'h00000005, 1'b1);
    check("fresh_acc",      w_out_acc,   40'h5);
    check("fresh_beats",    w_out_beats, 1);
    check("fresh_ovf",      w_out_ovf,   0);
    check("fresh_sat_acc",  s_out_acc,   40'h5);
    check("fresh_sat_ovf",  s_out_ovf,   0);
    take_result();

    // Mode 0 full-width overflow and beat counter saturation (257 beats)
    repeat (256) beat(1'b0, 32'hFFFFFFFF, 1'b0);
    beat(1'b0, 32'hFFFFFFFF, 1'b1);
    check("m0ovf_wrap_acc", w_out_acc,   40'h00FFFFFEFF);
    check("m0ovf_wrap_ovf", w_out_ovf,   1);
    check("m0ovf_beats",    w_out_beats, 255);
    check("m0ovf_sat_acc",  s_out_acc,   40'hFFFFFFFFFF);
    check("m0ovf_sat_ovf",  s_out_ovf,   1);
    take_result();

    // clear mid-burst wins over a simultaneous beat
    beat(1'b0, 32'h00000100, 1'b0);
    in_valid = 1'b1; in_product = 32'h00000200; in_last = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    check("clr_valid",    w_out_valid, 0);
    check("clr_acc",      w_out_acc,   0);
    check("clr_in_ready", w_in_ready,  1);
    beat(1'b0, 32'h00000007, 1'b1);
    check("clr_next_acc",   w_out_acc,   40'h7);
    check("clr_next_beats", w_out_beats, 1);

    // Async reset while holding a result acts before the next edge
    #2;
    resetb = 1'b0;
    #1;
    check("arst_valid",    w_out_valid, 0);
    check("arst_acc",      w_out_acc,   0);
    check("arst_in_ready", w_in_ready,  1);
    @(posedge clk); #1;
    resetb = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
